// File: rtl/ex_stage_mdu.sv
// Execute stage: latches one decoded instruction per handshake, computes ALU results,
// runs an iterative multiply/divide unit with HI/LO, and issues byte-strobed memory requests.

module alu #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 12
) (
  input  logic [OP_WIDTH-1:0]   alu_control,
  input  logic [DATA_WIDTH-1:0] alu_src1,
  input  logic [DATA_WIDTH-1:0] alu_src2,
  output logic [DATA_WIDTH-1:0] alu_result
);
  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0]        shamt_s;
  logic [DATA_WIDTH-1:0] sra_s;
  logic                  slt_s;
  logic                  sltu_s;

  // shift amount comes from src1, the shifted value from src2
  assign shamt_s = alu_src1[SHW-1:0];
  assign sra_s   = $unsigned($signed(alu_src2) >>> shamt_s);
  assign slt_s   = $signed(alu_src1) < $signed(alu_src2);
  assign sltu_s  = alu_src1 < alu_src2;

  // One-hot operation select
  always_comb begin
    alu_result = '0;
    if (alu_control[0]) begin
      alu_result = alu_src1 + alu_src2;
    end else if (alu_control[1]) begin
      alu_result = alu_src1 - alu_src2;
    end else if (alu_control[2]) begin
      alu_result = {{(DATA_WIDTH-1){1'b0}}, slt_s};
    end else if (alu_control[3]) begin
      alu_result = {{(DATA_WIDTH-1){1'b0}}, sltu_s};
    end else if (alu_control[4]) begin
      alu_result = alu_src1 & alu_src2;
    end else if (alu_control[5]) begin
      alu_result = ~(alu_src1 | alu_src2);
    end else if (alu_control[6]) begin
      alu_result = alu_src1 | alu_src2;
    end else if (alu_control[7]) begin
      alu_result = alu_src1 ^ alu_src2;
    end else if (alu_control[8]) begin
      alu_result = alu_src2 << shamt_s;
    end else if (alu_control[9]) begin
      alu_result = alu_src2 >> shamt_s;
    end else if (alu_control[10]) begin
      alu_result = sra_s;
    end else if (alu_control[11]) begin
      alu_result = alu_src2 << 5'd16;
    end else begin
      alu_result = '0;
    end
  end
endmodule

module ex_stage_mdu #(
  parameter int DATA_WIDTH   = 32,
  parameter int MUL_LATENCY  = 3,
  parameter int ALU_OP_WIDTH = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      ex_allow_in,
  input  logic [DATA_WIDTH-1:0]     in_program_count,
  input  logic [ALU_OP_WIDTH-1:0]   in_alu_operation,
  input  logic [DATA_WIDTH-1:0]     in_operand1,
  input  logic [DATA_WIDTH-1:0]     in_operand2,
  input  logic [3:0]                in_md_operation,
  input  logic                      in_memory_write,
  input  logic                      in_is_load,
  input  logic [1:0]                in_memory_size,
  input  logic [DATA_WIDTH-1:0]     in_store_data,
  input  logic [4:0]                in_destination_register,
  input  logic                      in_register_write,
  input  logic                      io_allow_in,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_program_count,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic [4:0]                out_destination_register,
  output logic                      out_register_write,
  output logic                      out_result_is_from_memory,
  output logic                      data_enabled,
  output logic [DATA_WIDTH/8-1:0]   data_write_enabled,
  output logic [DATA_WIDTH-1:0]     data_address,
  output logic [DATA_WIDTH-1:0]     data_write_data,
  output logic                      mdu_busy
);
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int OFS_W   = $clog2(STRB_W);
  localparam int CNT_MAX = (MUL_LATENCY > DATA_WIDTH) ? MUL_LATENCY : DATA_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [1:0] MAX_SIZE = 2'(OFS_W);

  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mdu_state_t;

  logic                    ex_valid_r;
  logic [DATA_WIDTH-1:0]   pc_r;
  logic [ALU_OP_WIDTH-1:0] alu_op_r;
  logic [DATA_WIDTH-1:0]   op1_r;
  logic [DATA_WIDTH-1:0]   op2_r;
  logic [3:0]              md_op_r;
  logic                    mem_write_r;
  logic                    is_load_r;
  logic [1:0]              mem_size_r;
  logic [DATA_WIDTH-1:0]   store_data_r;
  logic [4:0]              dest_r;
  logic                    reg_write_r;

  mdu_state_t              state_r;
  mdu_state_t              state_next_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_next_s;
  logic                    div_load_s;
  logic                    div_step_s;
  logic [DATA_WIDTH-1:0]   hi_r;
  logic [DATA_WIDTH-1:0]   lo_r;
  logic [DATA_WIDTH-1:0]   quo_r;
  logic [DATA_WIDTH-1:0]   rem_r;
  logic [DATA_WIDTH-1:0]   dvsr_r;

  logic                    is_mul_s;
  logic                    is_div_s;
  logic                    is_signed_s;
  logic                    ready_go_s;
  logic                    leave_s;
  logic                    commit_s;
  logic [DATA_WIDTH-1:0]   alu_result_s;

  logic [2*DATA_WIDTH-1:0] mul_a_s;
  logic [2*DATA_WIDTH-1:0] mul_b_s;
  logic [2*DATA_WIDTH-1:0] product_s;
  logic                    dividend_neg_s;
  logic                    divisor_neg_s;
  logic [DATA_WIDTH-1:0]   dividend_mag_s;
  logic [DATA_WIDTH-1:0]   divisor_mag_s;
  logic [DATA_WIDTH:0]     shifted_s;
  logic [DATA_WIDTH:0]     diff_s;
  logic [DATA_WIDTH-1:0]   quo_step_s;
  logic [DATA_WIDTH-1:0]   rem_step_s;
  logic [DATA_WIDTH-1:0]   div_hi_s;
  logic [DATA_WIDTH-1:0]   div_lo_s;
  logic [DATA_WIDTH-1:0]   mdu_hi_s;
  logic [DATA_WIDTH-1:0]   mdu_lo_s;

  logic [OFS_W-1:0]        ofs_s;
  logic [OFS_W-1:0]        low_mask_s;
  logic [STRB_W-1:0]       byte_mask_s;
  logic                    aligned_s;

  alu #(.DATA_WIDTH(DATA_WIDTH), .OP_WIDTH(ALU_OP_WIDTH)) u_alu (
    .alu_control (alu_op_r),
    .alu_src1    (op1_r),
    .alu_src2    (op2_r),
    .alu_result  (alu_result_s)
  );

  assign is_mul_s    = (md_op_r == MD_MULT) || (md_op_r == MD_MULTU);
  assign is_div_s    = (md_op_r == MD_DIV)  || (md_op_r == MD_DIVU);
  assign is_signed_s = (md_op_r == MD_MULT) || (md_op_r == MD_DIV);

  assign out_valid   = ex_valid_r && ready_go_s;
  assign leave_s     = out_valid && io_allow_in;
  assign commit_s    = leave_s && !flush;
  assign ex_allow_in = !flush && (!ex_valid_r || (ready_go_s && io_allow_in));

  // Instruction latch: fields captured only on an accepted handshake
  always_ff @(posedge clock) begin
    if (!reset) begin
      ex_valid_r   <= 1'b0;
      pc_r         <= '0;
      alu_op_r     <= '0;
      op1_r        <= '0;
      op2_r        <= '0;
      md_op_r      <= 4'd0;
      mem_write_r  <= 1'b0;
      is_load_r    <= 1'b0;
      mem_size_r   <= 2'd0;
      store_data_r <= '0;
      dest_r       <= 5'd0;
      reg_write_r  <= 1'b0;
    end else begin
      if (flush) begin
        ex_valid_r <= 1'b0;
      end else if (ex_allow_in) begin
        ex_valid_r <= in_valid;
      end
      if (in_valid && ex_allow_in) begin
        pc_r         <= in_program_count;
        alu_op_r     <= in_alu_operation;
        op1_r        <= in_operand1;
        op2_r        <= in_operand2;
        md_op_r      <= in_md_operation;
        mem_write_r  <= in_memory_write;
        is_load_r    <= in_is_load;
        mem_size_r   <= in_memory_size;
        store_data_r <= in_store_data;
        dest_r       <= in_destination_register;
        reg_write_r  <= in_register_write;
      end
    end
  end

  // MDU state and counter register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // MDU next state; DONE is reached on the cycle the counter would hit zero
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    div_load_s   = 1'b0;
    div_step_s   = 1'b0;
    if (flush) begin
      state_next_s = IDLE;
      cnt_next_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ex_valid_r && is_mul_s) begin
            if (MUL_LATENCY == 1) begin
              state_next_s = DONE;
              cnt_next_s   = '0;
            end else begin
              state_next_s = BUSY;
              cnt_next_s   = CNT_W'(MUL_LATENCY - 1);
            end
          end else if (ex_valid_r && is_div_s) begin
            state_next_s = BUSY;
            cnt_next_s   = CNT_W'(DATA_WIDTH);
            div_load_s   = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
        end
        BUSY: begin
          div_step_s = is_div_s;
          if (cnt_r <= CNT_W'(1)) begin
            state_next_s = DONE;
            cnt_next_s   = '0;
          end else begin
            cnt_next_s   = cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          if (leave_s) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DONE;
          end
        end
        default: begin
          state_next_s = IDLE;
          cnt_next_s   = '0;
        end
      endcase
    end
  end

  // MDU-derived stage outputs
  always_comb begin
    ready_go_s = 1'b1;
    mdu_busy   = (state_r == BUSY);
    if (is_mul_s || is_div_s) begin
      ready_go_s = (state_r == DONE);
    end else begin
      ready_go_s = 1'b1;
    end
  end

  assign mul_a_s   = {{DATA_WIDTH{is_signed_s & op1_r[DATA_WIDTH-1]}}, op1_r};
  assign mul_b_s   = {{DATA_WIDTH{is_signed_s & op2_r[DATA_WIDTH-1]}}, op2_r};
  assign product_s = mul_a_s * mul_b_s;

  assign dividend_neg_s = is_signed_s && op1_r[DATA_WIDTH-1];
  assign divisor_neg_s  = is_signed_s && op2_r[DATA_WIDTH-1];
  assign dividend_mag_s = dividend_neg_s ? -op1_r : op1_r;
  assign divisor_mag_s  = divisor_neg_s  ? -op2_r : op2_r;

  // One restoring step: shift in the next dividend bit and try to subtract
  always_comb begin
    shifted_s = {rem_r, quo_r[DATA_WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dvsr_r};
    if (!diff_s[DATA_WIDTH]) begin
      rem_step_s = diff_s[DATA_WIDTH-1:0];
      quo_step_s = {quo_r[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_step_s = shifted_s[DATA_WIDTH-1:0];
      quo_step_s = {quo_r[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Divider datapath registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      quo_r  <= '0;
      rem_r  <= '0;
      dvsr_r <= '0;
    end else if (div_load_s) begin
      quo_r  <= dividend_mag_s;
      rem_r  <= '0;
      dvsr_r <= divisor_mag_s;
    end else if (div_step_s) begin
      quo_r  <= quo_step_s;
      rem_r  <= rem_step_s;
    end
  end

  // Divide sign fix-up and architectural corner cases
  always_comb begin
    div_lo_s = dividend_neg_s ^ divisor_neg_s ? -quo_r : quo_r;
    div_hi_s = dividend_neg_s ? -rem_r : rem_r;
    if (op2_r == '0) begin
      div_lo_s = '1;
      div_hi_s = op1_r;
    end else if (is_signed_s && (op1_r == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (op2_r == '1)) begin
      div_lo_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      div_hi_s = '0;
    end else begin
      div_lo_s = dividend_neg_s ^ divisor_neg_s ? -quo_r : quo_r;
      div_hi_s = dividend_neg_s ? -rem_r : rem_r;
    end
  end

  assign mdu_hi_s = is_mul_s ? product_s[2*DATA_WIDTH-1:DATA_WIDTH] : div_hi_s;
  assign mdu_lo_s = is_mul_s ? product_s[DATA_WIDTH-1:0]            : div_lo_s;

  // HI/LO commit on leave only
  always_ff @(posedge clock) begin
    if (!reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (commit_s) begin
      case (md_op_r)
        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
          hi_r <= mdu_hi_s;
          lo_r <= mdu_lo_s;
        end
        MD_MTHI: hi_r <= op1_r;
        MD_MTLO: lo_r <= op1_r;
        default: begin
          hi_r <= hi_r;
          lo_r <= lo_r;
        end
      endcase
    end
  end

  // Result selection
  always_comb begin
    case (md_op_r)
      MD_MFHI:                            out_result = hi_r;
      MD_MFLO:                            out_result = lo_r;
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: out_result = mdu_lo_s;
      default:                            out_result = alu_result_s;
    endcase
  end

  assign out_program_count         = pc_r;
  assign out_destination_register  = dest_r;
  assign out_register_write        = reg_write_r;
  assign out_result_is_from_memory = is_load_r;

  assign ofs_s        = alu_result_s[OFS_W-1:0];
  assign data_address = alu_result_s;

  // Access-size masks: low_mask covers offset bits that must be zero, byte_mask the lanes
  always_comb begin
    case (mem_size_r)
      2'd0: begin low_mask_s = OFS_W'(3'd0); byte_mask_s = STRB_W'(8'h01); end
      2'd1: begin low_mask_s = OFS_W'(3'd1); byte_mask_s = STRB_W'(8'h03); end
      2'd2: begin low_mask_s = OFS_W'(3'd3); byte_mask_s = STRB_W'(8'h0F); end
      2'd3: begin low_mask_s = OFS_W'(3'd7); byte_mask_s = STRB_W'(8'hFF); end
      default: begin low_mask_s = '0; byte_mask_s = '0; end
    endcase
  end

  assign aligned_s    = (mem_size_r <= MAX_SIZE) && ((ofs_s & low_mask_s) == '0);
  assign data_enabled = ex_valid_r && (is_load_r || mem_write_r) && leave_s && !flush && aligned_s;
  assign data_write_enabled = (data_enabled && mem_write_r) ? (byte_mask_s << ofs_s) : '0;

  // Replicate the low 2^size bytes of store data across every lane
  always_comb begin
    data_write_data = '0;
    for (int i = 0; i < STRB_W; i++) begin
      data_write_data[8*i +: 8] = store_data_r[8*int'(OFS_W'(i) & low_mask_s) +: 8];
    end
  end
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: table of single-cycle ops plus hand sequences for
// multiply/divide latency, stalls, flush and mid-operation reset.

module tb_ex_stage_mdu;
  localparam logic [11:0] ALU_ADD  = 12'h001;
  localparam logic [11:0] ALU_SUB  = 12'h002;
  localparam logic [11:0] ALU_SLT  = 12'h004;
  localparam logic [11:0] ALU_SLTU = 12'h008;
  localparam logic [11:0] ALU_AND  = 12'h010;
  localparam logic [11:0] ALU_SRA  = 12'h400;
  localparam logic [11:0] ALU_LUI  = 12'h800;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        ex_allow_in;
  logic [31:0] in_program_count;
  logic [11:0] in_alu_operation;
  logic [31:0] in_operand1;
  logic [31:0] in_operand2;
  logic [3:0]  in_md_operation;
  logic        in_memory_write;
  logic        in_is_load;
  logic [1:0]  in_memory_size;
  logic [31:0] in_store_data;
  logic [4:0]  in_destination_register;
  logic        in_register_write;
  logic        io_allow_in;
  logic        out_valid;
  logic [31:0] out_program_count;
  logic [31:0] out_result;
  logic [4:0]  out_destination_register;
  logic        out_register_write;
  logic        out_result_is_from_memory;
  logic        data_enabled;
  logic [3:0]  data_write_enabled;
  logic [31:0] data_address;
  logic [31:0] data_write_data;
  logic        mdu_busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [11:0] aop;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  md;
    logic        wr;
    logic        ld;
    logic [1:0]  sz;
    logic [31:0] sd;
    logic [31:0] exp_res;
    logic        exp_de;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[17];

  ex_stage_mdu dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .ex_allow_in(ex_allow_in), .in_program_count(in_program_count),
    .in_alu_operation(in_alu_operation), .in_operand1(in_operand1),
    .in_operand2(in_operand2), .in_md_operation(in_md_operation),
    .in_memory_write(in_memory_write), .in_is_load(in_is_load),
    .in_memory_size(in_memory_size), .in_store_data(in_store_data),
    .in_destination_register(in_destination_register),
    .in_register_write(in_register_write), .io_allow_in(io_allow_in),
    .out_valid(out_valid), .out_program_count(out_program_count),
    .out_result(out_result), .out_destination_register(out_destination_register),
    .out_register_write(out_register_write),
    .out_result_is_from_memory(out_result_is_from_memory),
    .data_enabled(data_enabled), .data_write_enabled(data_write_enabled),
    .data_address(data_address), .data_write_data(data_write_data),
    .mdu_busy(mdu_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] aop, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] md, input logic wr,
                       input logic ld, input logic [1:0] sz, input logic [31:0] sd);
    in_valid                = v;
    in_alu_operation        = aop;
    in_operand1             = a;
    in_operand2             = b;
    in_md_operation         = md;
    in_memory_write         = wr;
    in_is_load              = ld;
    in_memory_size          = sz;
    in_store_data           = sd;
    in_program_count        = in_program_count + 32'd4;
    in_destination_register = 5'd3;
    in_register_write       = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"},   32'(out_valid), 32'd0);
    check({tag, " mdu_busy"},    32'(mdu_busy), 32'd0);
    check({tag, " data_en"},     32'(data_enabled), 32'd0);
    check({tag, " strobes"},     32'(data_write_enabled), 32'd0);
    check({tag, " ex_allow_in"}, 32'(ex_allow_in), 32'd1);
  endtask

  // Issue MULT/DIV, measure cycles until out_valid, optionally hold it downstream
  task automatic run_mdu(input string name, input logic [3:0] md, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_lo,
                         input int hold);
    int cyc;
    int allow_low;
    drive(1'b1, ALU_ADD, a, b, md, 1'b0, 1'b0, 2'd0, 32'd0);
    tick();
    in_valid    = 1'b0;
    io_allow_in = (hold == 0);
    cyc = 0;
    allow_low = 0;
    #1;
    while (out_valid !== 1'b1 && cyc < 200) begin
      if (ex_allow_in === 1'b0) allow_low++;
      if (cyc == 1) check({name, " busy@1"}, 32'(mdu_busy), 32'd1);
      @(posedge clock);
      #2;
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(exp_lat));
    check({name, " allow_in low cycles"}, 32'(allow_low), 32'(exp_lat));
    check({name, " lo result"}, out_result, exp_lo);
    for (int k = 0; k < hold; k++) begin
      @(posedge clock);
      #2;
      check({name, " held valid"}, 32'(out_valid), 32'd1);
      check({name, " held result"}, out_result, exp_lo);
    end
    io_allow_in = 1'b1;
  endtask

  task automatic read_hl(input string name, input logic [3:0] md, input logic [31:0] exp);
    drive(1'b1, ALU_ADD, 32'd0, 32'd0, md, 1'b0, 1'b0, 2'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    check({name, " valid"}, 32'(out_valid), 32'd1);
    check(name, out_result, exp);
  endtask

  initial begin
    int pulses;
    vecs[0]  = '{ALU_ADD,  32'd5,         32'd7,          4'd0, 1'b0, 1'b0, 2'd0, 32'd0,        32'd12,        1'b0, 4'b0000, 32'd0};
    vecs[1]  = '{ALU_SUB,  32'd5,         32'd7,          4'd0, 1'b0, 1'b0, 2'd0, 32'd0,        32'hFFFFFFFE,  1'b0, 4'b0000, 32'd0};
    vecs[2]  = '{ALU_SLT,  32'hFFFFFFFF,  32'd1,          4'd0, 1'b0, 1'b0, 2'd0, 32'd0,        32'd1,         1'b0, 4'b0000, 32'd0};
    vecs[3]  = '{ALU_SLTU, 32'hFFFFFFFF,  32'd1,          4'd0, 1'b0, 1'b0, 2'd0, 32'd0,        32'd0,         1'b0, 4'b0000, 32'd0};
    vecs[4]  = '{ALU_AND,  32'hF0F0F0F0,  32'h0FF00FF0,   4'd0, 1'b0, 1'b0, 2'd0, 32'd0,        32'h00F000F0,  1'b0, 4'b0000, 32'd0};
    vecs[5]  = '{ALU_SRA,  32'd4,         32'h80000000,   4'd0, 1'b0, 1'b0, 2'd0, 32'd0,        32'hF8000000,  1'b0, 4'b0000, 32'd0};
    vecs[6]  = '{ALU_LUI,  32'd0,         32'h00001234,   4'd0, 1'b0, 1'b0, 2'd0, 32'd0,        32'h12340000,  1'b0, 4'b0000, 32'd0};
    vecs[7]  = '{ALU_ADD,  32'hCAFE0001,  32'd0,          4'd7, 1'b0, 1'b0, 2'd0, 32'd0,        32'hCAFE0001,  1'b0, 4'b0000, 32'd0};
    vecs[8]  = '{ALU_ADD,  32'd0,         32'd0,          4'd5, 1'b0, 1'b0, 2'd0, 32'd0,        32'hCAFE0001,  1'b0, 4'b0000, 32'd0};
    vecs[9]  = '{ALU_ADD,  32'h12345678,  32'd0,          4'd8, 1'b0, 1'b0, 2'd0, 32'd0,        32'h12345678,  1'b0, 4'b0000, 32'd0};
    vecs[10] = '{ALU_ADD,  32'd0,         32'd0,          4'd6, 1'b0, 1'b0, 2'd0, 32'd0,        32'h12345678,  1'b0, 4'b0000, 32'd0};
    vecs[11] = '{ALU_ADD,  32'h00001000,  32'd3,          4'd0, 1'b1, 1'b0, 2'd0, 32'h000000AB, 32'h00001003,  1'b1, 4'b1000, 32'hABABABAB};
    vecs[12] = '{ALU_ADD,  32'h00001000,  32'd1,          4'd0, 1'b1, 1'b0, 2'd1, 32'h00001234, 32'h00001001,  1'b0, 4'b0000, 32'd0};
    vecs[13] = '{ALU_ADD,  32'h00002000,  32'd0,          4'd0, 1'b1, 1'b0, 2'd2, 32'h11223344, 32'h00002000,  1'b1, 4'b1111, 32'h11223344};
    vecs[14] = '{ALU_ADD,  32'h00002000,  32'd2,          4'd0, 1'b1, 1'b0, 2'd1, 32'h0000BEEF, 32'h00002002,  1'b1, 4'b1100, 32'hBEEFBEEF};
    vecs[15] = '{ALU_ADD,  32'h00003000,  32'd0,          4'd0, 1'b0, 1'b1, 2'd2, 32'd0,        32'h00003000,  1'b1, 4'b0000, 32'd0};
    vecs[16] = '{ALU_ADD,  32'h00003000,  32'd2,          4'd0, 1'b0, 1'b1, 2'd2, 32'd0,        32'h00003002,  1'b0, 4'b0000, 32'd0};

    reset = 1'b0;
    flush = 1'b0;
    io_allow_in = 1'b1;
    in_program_count = 32'h00400000;
    drive(1'b0, 12'h000, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 2'd0, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // Back-to-back single-cycle ops: vector i enters while vector i-1 is checked
    for (int i = 0; i <= 17; i++) begin
      if (i < 17) begin
        drive(1'b1, vecs[i].aop, vecs[i].a, vecs[i].b, vecs[i].md, vecs[i].wr,
              vecs[i].ld, vecs[i].sz, vecs[i].sd);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        check($sformatf("vec%0d out_valid", i-1), 32'(out_valid), 32'd1);
        check($sformatf("vec%0d ex_allow_in", i-1), 32'(ex_allow_in), 32'd1);
        check($sformatf("vec%0d result", i-1), out_result, vecs[i-1].exp_res);
        check($sformatf("vec%0d data_en", i-1), 32'(data_enabled), 32'(vecs[i-1].exp_de));
        check($sformatf("vec%0d strobes", i-1), 32'(data_write_enabled), 32'(vecs[i-1].exp_strb));
        if (vecs[i-1].exp_de && vecs[i-1].wr)
          check($sformatf("vec%0d wdata", i-1), data_write_data, vecs[i-1].exp_wdata);
      end
      tick();
    end

    run_mdu("MULT", 4'd1, 32'hFFFFFFFF, 32'd2, 3, 32'hFFFFFFFE, 0);
    read_hl("MULT mfhi", 4'd5, 32'hFFFFFFFF);
    read_hl("MULT mflo", 4'd6, 32'hFFFFFFFE);
    run_mdu("MULTU", 4'd2, 32'hFFFFFFFF, 32'd2, 3, 32'hFFFFFFFE, 0);
    read_hl("MULTU mfhi", 4'd5, 32'h00000001);
    run_mdu("DIV", 4'd3, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 0);
    read_hl("DIV mfhi", 4'd5, 32'hFFFFFFFF);
    run_mdu("DIVU0", 4'd4, 32'h00001234, 32'd0, 33, 32'hFFFFFFFF, 0);
    read_hl("DIVU0 mfhi", 4'd5, 32'h00001234);
    run_mdu("DIVMIN", 4'd3, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 0);
    read_hl("DIVMIN mfhi", 4'd5, 32'h00000000);
    run_mdu("MULT stall", 4'd1, 32'd3, 32'd5, 3, 32'd15, 3);
    read_hl("MULT stall mflo", 4'd6, 32'd15);
    run_mdu("DIVU", 4'd4, 32'd100, 32'd7, 33, 32'd14, 0);
    read_hl("DIVU mfhi", 4'd5, 32'd2);

    // Store held by downstream for 4 cycles must pulse exactly once
    tick();
    io_allow_in = 1'b0;
    drive(1'b1, ALU_ADD, 32'h00001000, 32'd3, 4'd0, 1'b1, 1'b0, 2'd0, 32'h000000AB);
    tick();
    in_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) io_allow_in = 1'b1;
      #1;
      if (data_enabled === 1'b1) begin
        pulses++;
        check("stall store strobes", 32'(data_write_enabled), 32'h8);
      end
      tick();
    end
    check("stall store pulses", 32'(pulses), 32'd1);

    // Flush in the same cycle as a store's leave: no request
    drive(1'b1, ALU_ADD, 32'h00002000, 32'd0, 4'd0, 1'b1, 1'b0, 2'd2, 32'h11223344);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("flush store data_en", 32'(data_enabled), 32'd0);
    check("flush ex_allow_in", 32'(ex_allow_in), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("post flush out_valid", 32'(out_valid), 32'd0);

    // Flushed MTHI must not write HI
    drive(1'b1, ALU_ADD, 32'h00000777, 32'd0, 4'd7, 1'b0, 1'b0, 2'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    read_hl("flushed mthi mfhi", 4'd5, 32'd2);

    // Flush in cycle 10 of a divide
    drive(1'b1, ALU_ADD, 32'hFFFFFFF9, 32'd2, 4'd3, 1'b0, 1'b0, 2'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    #1;
    check("div c10 busy", 32'(mdu_busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("div flush busy", 32'(mdu_busy), 32'd0);
    check("div flush valid", 32'(out_valid), 32'd0);
    check("div flush allow", 32'(ex_allow_in), 32'd1);
    read_hl("div flush mflo", 4'd6, 32'd14);
    read_hl("div flush mfhi", 4'd5, 32'd2);

    // Reset while a multiply is busy
    drive(1'b1, ALU_ADD, 32'd3, 32'd5, 4'd1, 1'b0, 1'b0, 2'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    check("mult busy before reset", 32'(mdu_busy), 32'd1);
    reset = 1'b0;
    tick();
    check_reset_outputs("mid reset");
    reset = 1'b1;
    read_hl("reset mfhi", 4'd5, 32'd0);
    read_hl("reset mflo", 4'd6, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
